// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with internal bit timer, framing and false-start detection
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       active_f,
  output logic       frame_err_o,
  output logic       parity_err_o
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
`ifdef UART_RX_PARITY_EN
    , PARITY = 3'd5
`endif
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;
  logic        frame_err_q, frame_err_d;
  logic        bit_tick;
`ifdef UART_RX_PARITY_EN
  logic        parity_err_q, parity_err_d;
  logic        parity_bad_q, parity_bad_d;
`endif

  assign bit_tick = (clk_cnt_q == BIT_LAST);

  always_comb begin
    rx_meta_d   = rx_i;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    parity_bad_d = parity_bad_q;
`endif

    case (state_q)
      IDLE: begin
        clk_cnt_d = 16'd0;
        bit_idx_d = 3'd0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end

      // Re-check the line at mid start bit so short glitches are rejected.
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = 16'd0;
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end

      DATA: begin
        if (bit_tick) begin
          clk_cnt_d          = 16'd0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          clk_cnt_d    = 16'd0;
          parity_bad_d = (^shift_q) ^ rx_s_q;
          state_d      = STOP;
        end
      end
`endif

      // A low stop bit wins over any parity result.
      STOP: begin
        if (bit_tick) begin
          clk_cnt_d = 16'd0;
          state_d   = CLEANUP;
          if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
            if (parity_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end

      CLEANUP: begin
        clk_cnt_d = 16'd0;
        state_d   = IDLE;
      end

      default: begin
        clk_cnt_d = 16'd0;
        state_d   = IDLE;
      end
    endcase

    active_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
`ifdef UART_RX_PARITY_EN
    if (state_d == PARITY) begin
      active_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      clk_cnt_q   <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      parity_bad_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      parity_bad_q <= parity_bad_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign active_f    = active_q;
  assign frame_err_o = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver at CLKS_PER_BIT=16
module tb_uart_receiver;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int LAT        = 171;
`else
  localparam int FRAME_BITS = 10;
  localparam int LAT        = 155;
`endif

  logic       clk;
  logic       reset_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       active_f;
  logic       frame_err_o;
  logic       parity_err_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int         nv = 0, nf = 0, np = 0, strobe_bad = 0, act_cnt = 0, last_active = 0;
  int         v_cyc_last = 0, v_cyc_prev = 0, f_cyc = 0;
  logic [7:0] v_data_last = 8'h00, v_data_prev = 8'h00;
  logic       prev_valid = 1'b0, prev_ferr = 1'b0;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .active_f    (active_f),
    .frame_err_o (frame_err_o),
    .parity_err_o(parity_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o) begin
      v_cyc_prev  = v_cyc_last;
      v_data_prev = v_data_last;
      v_cyc_last  = cyc;
      v_data_last = data_o;
      nv++;
    end
    if (frame_err_o) begin
      f_cyc = cyc;
      nf++;
    end
    if (parity_err_o) np++;
    if ((valid_o && prev_valid) || (frame_err_o && prev_ferr) || (valid_o && frame_err_o)) strobe_bad++;
    prev_valid = valid_o;
    prev_ferr  = frame_err_o;
    if (active_f) begin
      act_cnt++;
      last_active = cyc;
    end
  end

  function automatic logic [FRAME_BITS-1:0] frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {stop, ^d, d, 1'b0};
`else
    return {stop, d, 1'b0};
`endif
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [FRAME_BITS-1:0] bits, output int fall);
    fall = cyc;
    for (int i = 0; i < FRAME_BITS; i++) begin
      rx_i = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    rx_i    = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=00", data_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
    checks++; if (active_f !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b exp=0", active_f); end
    checks++; if (frame_err_o !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%0b exp=0", frame_err_o); end
    checks++; if (parity_err_o !== 1'b0) begin failures++; $display("FAIL reset_perr got=%0b exp=0", parity_err_o); end
    reset_i = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_single();
    int fall, v0, f0;
    v0 = nv; f0 = nf;
    align();
    send_bits(frame(8'h55, 1'b1), fall);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (nv - v0 !== 1) begin failures++; $display("FAIL single_valid_count got=%0d exp=1", nv - v0); end
    checks++; if (data_o !== 8'h55) begin failures++; $display("FAIL single_data got=%0h exp=55", data_o); end
    checks++; if (nf - f0 !== 0) begin failures++; $display("FAIL single_ferr_count got=%0d exp=0", nf - f0); end
    checks++; if (v_cyc_last - fall !== LAT) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", v_cyc_last - fall, LAT); end
  endtask

  task automatic test_back_to_back();
    int fall_a, fall_b, v0;
    v0 = nv;
    align();
    send_bits(frame(8'hA3, 1'b1), fall_a);
    send_bits(frame(8'h0F, 1'b1), fall_b);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (nv - v0 !== 2) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=2", nv - v0); end
    checks++; if (v_data_prev !== 8'hA3) begin failures++; $display("FAIL b2b_first_data got=%0h exp=a3", v_data_prev); end
    checks++; if (v_data_last !== 8'h0F) begin failures++; $display("FAIL b2b_second_data got=%0h exp=0f", v_data_last); end
    checks++; if (v_cyc_last - v_cyc_prev !== CPB * FRAME_BITS) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", v_cyc_last - v_cyc_prev, CPB * FRAME_BITS); end
    checks++; if (fall_b - fall_a !== CPB * FRAME_BITS) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", fall_b - fall_a, CPB * FRAME_BITS); end
  endtask

  task automatic test_glitch();
    int rise, fall, v0, f0, a0;
    v0 = nv; f0 = nf; a0 = act_cnt;
    align();
    rx_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_i = 1'b1;
    rise = cyc;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (active_f !== 1'b0) begin failures++; $display("FAIL glitch_active_end got=%0b exp=0", active_f); end
    checks++; if (act_cnt - a0 !== 8) begin failures++; $display("FAIL glitch_active_cycles got=%0d exp=8", act_cnt - a0); end
    checks++; if (last_active - rise > 10) begin failures++; $display("FAIL glitch_active_drop got=%0d exp<=10", last_active - rise); end
    checks++; if (nv - v0 !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", nv - v0); end
    checks++; if (nf - f0 !== 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", nf - f0); end
    repeat (10) @(posedge clk);
    align();
    send_bits(frame(8'h7E, 1'b1), fall);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (nv - v0 !== 1) begin failures++; $display("FAIL after_glitch_valid got=%0d exp=1", nv - v0); end
    checks++; if (data_o !== 8'h7E) begin failures++; $display("FAIL after_glitch_data got=%0h exp=7e", data_o); end
  endtask

  task automatic test_frame_err();
    int fall, v0, f0;
    v0 = nv; f0 = nf;
    align();
    send_bits(frame(8'hC4, 1'b0), fall);
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++; if (nf - f0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", nf - f0); end
    checks++; if (nv - v0 !== 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", nv - v0); end
    checks++; if (data_o !== 8'h7E) begin failures++; $display("FAIL ferr_data_hold got=%0h exp=7e", data_o); end
    checks++; if (f_cyc - fall !== LAT) begin failures++; $display("FAIL ferr_latency got=%0d exp=%0d", f_cyc - fall, LAT); end
    checks++; if (active_f !== 1'b0) begin failures++; $display("FAIL ferr_active_end got=%0b exp=0", active_f); end
  endtask

  task automatic test_reset_mid_frame();
    int fall, v0;
    v0 = nv;
    align();
    rx_i = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (69) @(posedge clk);
    #1;
    checks++; if (active_f !== 1'b1) begin failures++; $display("FAIL midrst_active_before got=%0b exp=1", active_f); end
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL midrst_data got=%0h exp=00", data_o); end
    checks++; if (active_f !== 1'b0) begin failures++; $display("FAIL midrst_active got=%0b exp=0", active_f); end
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++; if (nv - v0 !== 0) begin failures++; $display("FAIL midrst_no_strobe got=%0d exp=0", nv - v0); end
    align();
    send_bits(frame(8'h12, 1'b1), fall);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (nv - v0 !== 1) begin failures++; $display("FAIL midrst_next_valid got=%0d exp=1", nv - v0); end
    checks++; if (data_o !== 8'h12) begin failures++; $display("FAIL midrst_next_data got=%0h exp=12", data_o); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int fall, v0, p0;
    v0 = nv; p0 = np;
    align();
    send_bits({1'b1, 1'b1, 8'h01, 1'b0}, fall);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (nv - v0 !== 1) begin failures++; $display("FAIL par_good_valid got=%0d exp=1", nv - v0); end
    checks++; if (data_o !== 8'h01) begin failures++; $display("FAIL par_good_data got=%0h exp=01", data_o); end
    checks++; if (np - p0 !== 0) begin failures++; $display("FAIL par_good_perr got=%0d exp=0", np - p0); end
    align();
    send_bits({1'b1, 1'b0, 8'h01, 1'b0}, fall);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (np - p0 !== 1) begin failures++; $display("FAIL par_bad_perr got=%0d exp=1", np - p0); end
    checks++; if (nv - v0 !== 1) begin failures++; $display("FAIL par_bad_valid got=%0d exp=1", nv - v0); end
  endtask
`endif

  initial begin
    reset_i = 1'b1;
    rx_i    = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++; if (strobe_bad !== 0) begin failures++; $display("FAIL strobe_exclusive got=%0d exp=0", strobe_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
